// File: rtl/cpu_param.sv
// rtl/cpu_param.sv - parametrised multicycle lab CPU core with register file, shifter, ALU and control FSM
module cpu_param #(
  parameter int DATA_W    = 16,
  parameter bit FLAGS_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              err
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    st_wait,
    st_decode,
    st_get_a,
    st_get_b,
    st_alu,
    st_wr_reg,
    st_wr_imm
  } state_t;

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;

  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [1:0]        sh;
  logic [2:0]        rm;
  logic              is_movi;
  logic              is_movs;
  logic              is_alu;
  logic              upd_flags;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rm_sh;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v;

  assign opcode    = ir[15:13];
  assign op        = ir[12:11];
  assign rn        = ir[10:8];
  assign rd        = ir[7:5];
  assign sh        = ir[4:3];
  assign rm        = ir[2:0];
  assign is_movi   = (opcode == 3'b110) && (op == 2'b10);
  assign is_movs   = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu    = (opcode == 3'b101);
  // CMP always owns the flags; the other ALU ops only when FLAGS_ALL is set, MOVs never
  assign upd_flags = is_alu && ((op == 2'b01) || FLAGS_ALL);

  // Sign-extend imm8 to the full datapath width
  always_comb begin
    imm_ext      = {DATA_W{ir[7]}};
    imm_ext[7:0] = ir[7:0];
  end

  // B-operand shifter applied to the selected Rm register
  always_comb begin
    rm_sh = rf[rm];
    case (sh)
      2'b01:   rm_sh = {rf[rm][MSB-1:0], 1'b0};
      2'b10:   rm_sh = {1'b0, rf[rm][MSB:1]};
      2'b11:   rm_sh = {rf[rm][0], rf[rm][MSB:1]};
      default: rm_sh = rf[rm];
    endcase
  end

  // ALU on latched operands; MOV shifted reaches here with A cleared so A+B yields B
  always_comb begin
    alu_res = a + b;
    alu_v   = 1'b0;
    if (is_alu) begin
      case (op)
        2'b00: begin
          alu_res = a + b;
          alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
        end
        2'b01: begin
          alu_res = a - b;
          alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
        end
        2'b10:   alu_res = a & b;
        default: alu_res = ~b;
      endcase
    end
  end

  // Control FSM with registered outputs, IR, operand latches and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= st_wait;
      w     <= 1'b1;
      out   <= '0;
      N     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      err   <= 1'b0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        st_wait: begin
          if (load) ir <= in;
          if (s) begin
            state <= st_decode;
            w     <= 1'b0;
            err   <= 1'b0;
          end
        end
        st_decode: begin
          a <= '0;
          if (is_movi) begin
            state <= st_wr_imm;
          end else if (is_movs || (is_alu && (op == 2'b11))) begin
            state <= st_get_b;
          end else if (is_alu) begin
            state <= st_get_a;
          end else begin
            state <= st_wait;
            w     <= 1'b1;
            err   <= 1'b1;
          end
        end
        st_get_a: begin
          a     <= rf[rn];
          state <= st_get_b;
        end
        st_get_b: begin
          b     <= rm_sh;
          state <= st_alu;
        end
        st_alu: begin
          out <= alu_res;
          if (upd_flags) begin
            Z <= (alu_res == '0);
            N <= alu_res[MSB];
            V <= alu_v;
          end
          if (is_alu && (op == 2'b01)) begin
            state <= st_wait;
            w     <= 1'b1;
          end else begin
            state <= st_wr_reg;
          end
        end
        st_wr_reg: begin
          rf[rd] <= out;
          state  <= st_wait;
          w      <= 1'b1;
        end
        st_wr_imm: begin
          rf[rn] <= imm_ext;
          state  <= st_wait;
          w      <= 1'b1;
        end
        default: begin
          state <= st_wait;
          w     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// tb/tb_cpu_param.sv - scoreboard testbench for cpu_param at three parameter points
module tb_cpu_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic        load;
  logic [15:0] in;

  logic [15:0] out_a, out_b;
  logic [31:0] out_c;
  logic n_a, v_a, z_a, w_a, e_a;
  logic n_b, v_b, z_b, w_b, e_b;
  logic n_c, v_c, z_c, w_c, e_c;

  cpu_param #(.DATA_W(16), .FLAGS_ALL(1'b0)) u_a (
    .clk(clk), .reset(rst_n), .s(s), .load(load), .in(in),
    .out(out_a), .N(n_a), .V(v_a), .Z(z_a), .w(w_a), .err(e_a));
  cpu_param #(.DATA_W(16), .FLAGS_ALL(1'b1)) u_b (
    .clk(clk), .reset(rst_n), .s(s), .load(load), .in(in),
    .out(out_b), .N(n_b), .V(v_b), .Z(z_b), .w(w_b), .err(e_b));
  cpu_param #(.DATA_W(32), .FLAGS_ALL(1'b1)) u_c (
    .clk(clk), .reset(rst_n), .s(s), .load(load), .in(in),
    .out(out_c), .N(n_c), .V(v_c), .Z(z_c), .w(w_c), .err(e_c));

  always #5 clk = ~clk;

  logic [31:0] aout [3];
  logic [2:0]  an, av, az, ae, aw;
  assign aout[0] = {16'h0, out_a};
  assign aout[1] = {16'h0, out_b};
  assign aout[2] = out_c;
  assign an = {n_c, n_b, n_a};
  assign av = {v_c, v_b, v_a};
  assign az = {z_c, z_b, z_a};
  assign ae = {e_c, e_b, e_a};
  assign aw = {w_c, w_b, w_a};

  typedef struct packed {
    logic [7:0]       lat;
    logic [2:0][31:0] out;
    logic [2:0]       n;
    logic [2:0]       v;
    logic [2:0]       z;
    logic [2:0]       e;
  } exp_t;

  exp_t sb[$];
  int passed   = 0;
  int total    = 0;
  int done_cnt = 0;

  int unsigned     wid  [3] = '{16, 16, 32};
  bit              fall [3] = '{1'b0, 1'b1, 1'b1};
  longint unsigned mreg [3][8];
  longint unsigned mout [3];
  bit              mn [3];
  bit              mv [3];
  bit              mz [3];
  bit              merr [3];
  logic [15:0]     mir;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] movi(input int rn, input int imm);
    return {3'b110, 2'b10, 3'(rn), 8'(imm)};
  endfunction

  function automatic logic [15:0] movs(input int rd, input int rm, input int sh);
    return {3'b110, 2'b00, 3'b000, 3'(rd), 2'(sh), 3'(rm)};
  endfunction

  function automatic logic [15:0] alu(input int op, input int rn, input int rd, input int rm, input int sh);
    return {3'b101, 2'(op), 3'(rn), 3'(rd), 2'(sh), 3'(rm)};
  endfunction

  function automatic longint as_signed(input longint unsigned x, input int unsigned wd);
    longint unsigned half;
    half = 64'd1 << (wd - 1);
    return (x >= half) ? (longint'(x) - longint'(half << 1)) : longint'(x);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) mreg[k][r] = 0;
      mout[k] = 0; mn[k] = 0; mv[k] = 0; mz[k] = 0; merr[k] = 0;
    end
    mir = 16'h0;
  endtask

  // Architectural reference: applies the instruction held in mir to every configuration
  task automatic model_step(output exp_t e);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic [7:0] imm;
    bit is_mi, is_ms, is_al, upd, ovf;
    longint unsigned mask, half, a, b, r;
    longint sr;
    opc = mir[15:13]; op = mir[12:11]; rn = mir[10:8]; rd = mir[7:5];
    sh = mir[4:3]; rm = mir[2:0]; imm = mir[7:0];
    is_mi = (opc == 3'b110) && (op == 2'b10);
    is_ms = (opc == 3'b110) && (op == 2'b00);
    is_al = (opc == 3'b101);
    e = '0;
    if (is_mi) e.lat = 3;
    else if (is_ms || (is_al && op != 2'd0 && op != 2'd2)) e.lat = 5;
    else if (is_al) e.lat = 6;
    else e.lat = 2;
    for (int k = 0; k < 3; k++) begin
      mask = (64'd1 << wid[k]) - 1;
      half = 64'd1 << (wid[k] - 1);
      merr[k] = !(is_mi || is_ms || is_al);
      if (is_mi) begin
        mreg[k][rn] = (imm < 128) ? longint'(imm) : (mask + 1 - 256 + longint'(imm));
      end else if (is_ms || is_al) begin
        b = mreg[k][rm];
        case (sh)
          2'd1:    b = (b * 2) & mask;
          2'd2:    b = b / 2;
          2'd3:    b = b / 2 + (b % 2) * half;
          default: b = b;
        endcase
        a = is_ms ? 0 : mreg[k][rn];
        upd = is_al && (op == 2'd1 || fall[k]);
        sr = 0;
        if (is_ms) r = b;
        else begin
          case (op)
            2'd0: begin r = (a + b) & mask; sr = as_signed(a, wid[k]) + as_signed(b, wid[k]); end
            2'd1: begin r = (a + mask + 1 - b) & mask; sr = as_signed(a, wid[k]) - as_signed(b, wid[k]); end
            2'd2: r = a & b;
            default: r = mask - b;
          endcase
        end
        ovf = (sr < -longint'(half)) || (sr > longint'(half) - 1);
        mout[k] = r;
        if (upd) begin
          mz[k] = (r == 0);
          mn[k] = (r >= half);
          mv[k] = ovf;
        end
        if (!(is_al && op == 2'd1)) mreg[k][rd] = r;
      end
      e.out[k] = mout[k][31:0];
      e.n[k] = mn[k]; e.v[k] = mv[k]; e.z[k] = mz[k]; e.e[k] = merr[k];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [15:0] instr, input bit do_load = 1'b1,
                       input bit mid = 1'b0, input logic [15:0] mid_word = 16'h0);
    exp_t e;
    int d0;
    if (do_load) mir = instr;
    model_step(e);
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk); #1;
    in = instr; load = do_load; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    if (mid) begin
      @(negedge clk);
      in = mid_word; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
    end
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      total++;
      $display("FAIL timeout instr=0x%04h: w not back within 20 cycles, required latency %0d", instr, e.lat);
      do_reset();
    end
  endtask

  task automatic load_only(input logic [15:0] instr);
    mir = instr;
    @(negedge clk); #1;
    in = instr; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Monitor: measures w-low span and compares every completion against the scoreboard head
  initial begin
    int lowcnt;
    exp_t e;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) lowcnt = 0;
      else if (!w_a) lowcnt++;
      else if (lowcnt > 0) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected completion: got instruction end, required none pending");
        end else begin
          e = sb.pop_front();
          check("latency", lowcnt + 1, e.lat);
          check("w_b", aw[1], 1);
          check("w_c", aw[2], 1);
          for (int k = 0; k < 3; k++) begin
            check($sformatf("out[%0d]", k), aout[k], e.out[k]);
            check($sformatf("N[%0d]", k), an[k], e.n[k]);
            check($sformatf("V[%0d]", k), av[k], e.v[k]);
            check($sformatf("Z[%0d]", k), az[k], e.z[k]);
            check($sformatf("err[%0d]", k), ae[k], e.e[k]);
          end
        end
        lowcnt = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out[%0d]", k), aout[k], 0);
      check($sformatf("reset NVZ[%0d]", k), {an[k], av[k], az[k]}, 0);
      check($sformatf("reset err[%0d]", k), ae[k], 0);
      check($sformatf("reset w[%0d]", k), aw[k], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    issue(movi(0, 7));
    issue(movs(1, 0, 1));
    issue(alu(0, 1, 2, 0, 1));
    issue(movs(7, 2, 0));

    issue(movi(1, 8'h40));
    repeat (8) issue(movs(1, 1, 1));
    issue(alu(3, 0, 2, 1, 0));
    issue(alu(1, 1, 0, 2, 0));
    issue(alu(1, 3, 0, 3, 0));
    for (int r = 0; r < 8; r++) issue(movs(r, r, 0));

    issue(movi(0, 8'hFF));
    issue(movs(0, 0, 0));
    issue(movi(0, 1));
    issue(movs(0, 0, 3));
    issue(movs(0, 0, 2));

    issue(movi(4, 1));
    issue(movi(5, 8'hFF));
    issue(alu(1, 4, 0, 5, 0));
    issue(alu(0, 4, 6, 5, 0));
    issue(movs(4, 4, 3));
    issue(alu(3, 0, 4, 4, 0));
    issue(movi(5, 1));
    issue(alu(0, 4, 6, 5, 0));
    issue(alu(2, 4, 3, 4, 2));

    issue(16'hE000);
    issue(16'hC800);
    issue(16'hD800);
    issue(movs(6, 6, 0));
    issue(movi(3, 2));

    load_only(movi(6, 8'h5A));
    issue(16'hE000, 1'b0);
    issue(alu(0, 6, 7, 6, 0), 1'b1, 1'b1, movi(7, 8'h11));
    issue(16'h0000, 1'b0);

    issue(movi(0, 5));
    issue(movs(1, 0, 0));
    issue(alu(1, 7, 0, 0, 0));
    mir = alu(0, 0, 2, 1, 0);
    @(negedge clk); #1;
    in = mir; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort w[%0d]", k), aw[k], 1);
      check($sformatf("abort out[%0d]", k), aout[k], 0);
      check($sformatf("abort NVZ[%0d]", k), {an[k], av[k], az[k]}, 0);
    end
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(movs(3, 2, 0));

    for (int i = 0; i < 200; i++) begin
      int c;
      logic [15:0] word;
      c = int'($urandom_range(0, 9));
      if (c <= 1) word = movi(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      else if (c == 2) word = movs(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      else if (c <= 7) word = alu(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      else begin
        do word = 16'($urandom);
        while (word[15:13] == 3'b101 || (word[15:13] == 3'b110 && word[11] == 1'b0));
      end
      issue(word, (c == 9) ? 1'b0 : 1'b1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
